// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the CPU memory-data register unit.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 9;
  localparam int CPU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_FINISH  = 2'd3
  } mem_state_e;

  function automatic logic is_wait(input mem_state_e st);
    return (st == ST_RD_WAIT) || (st == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/mdr_mem_unit.sv
// MAR/MDR pair with a handshaked memory port: one outstanding read or write,
// bounded wait for mem_ack, done/err pulses and a sticky error flag.
module mdr_mem_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int TIMEOUT = CPU_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       busMuxIn_MDR,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              err_flag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_r, state_s;
  logic [ADDR_W-1:0] mar_r, mar_s;
  logic [31:0]       mdr_r, mdr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              err_flag_r, err_flag_s;
  logic              timeout_s;
  logic              req_r, we_r, busy_r, done_r, err_r;

  // Next-state, wait counter and MAR/MDR load selection
  always_comb begin
    state_s    = state_r;
    mar_s      = mar_r;
    mdr_s      = mdr_r;
    cnt_s      = cnt_r;
    err_flag_s = err_flag_r;
    timeout_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (Read) begin
          state_s    = ST_RD_WAIT;
          err_flag_s = 1'b0;
        end else if (Write) begin
          state_s    = ST_WR_WAIT;
          err_flag_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (mem_ack) begin
          state_s = ST_FINISH;
          mdr_s   = mem_rdata;
        end else if (cnt_r == CNT_LAST) begin
          state_s    = ST_IDLE;
          timeout_s  = 1'b1;
          err_flag_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (mem_ack) begin
          state_s = ST_FINISH;
        end else if (cnt_r == CNT_LAST) begin
          state_s    = ST_IDLE;
          timeout_s  = 1'b1;
          err_flag_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase

    // Bus loads are locked out only while the memory is looking at MAR/MDR;
    // in FINISH an MDRin overrides the just-captured read data.
    if (MARin && !is_wait(state_r)) begin
      mar_s = BusMuxOut[ADDR_W-1:0];
    end else begin
      mar_s = mar_r;
    end
    if (MDRin && !is_wait(state_r)) begin
      mdr_s = BusMuxOut;
    end else begin
      mdr_s = mdr_s;
    end
  end

  // State, datapath registers and outputs decoded from the next state
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r    <= ST_IDLE;
      mar_r      <= '0;
      mdr_r      <= 32'h0000_0000;
      cnt_r      <= '0;
      err_flag_r <= 1'b0;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      mar_r      <= mar_s;
      mdr_r      <= mdr_s;
      cnt_r      <= cnt_s;
      err_flag_r <= err_flag_s;
      req_r      <= is_wait(state_s);
      we_r       <= (state_s == ST_WR_WAIT);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_FINISH);
      err_r      <= timeout_s;
    end
  end

  assign mem_req      = req_r;
  assign mem_we       = we_r;
  assign mem_addr     = mar_r;
  assign mem_wdata    = mdr_r;
  assign busMuxIn_MDR = mdr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign err_flag     = err_flag_r;

endmodule
